// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a byte FIFO, exposed as DATA/STATUS I/O registers on the CPU data bus.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_port #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] BASE_ADDR    = 16'hFF10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [15:0] d_addr,
    inout  wire  [15:0] d_bus,
    output logic        irq
);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          NW        = AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_bad_q, par_bad_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic            push_req, frame_set, par_set;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]   count_q, count_d;
    logic            io_read_q, irq_q;
    logic            ovr_q, frm_err_q, par_err_q;
    logic            hit_data, hit_stat, full, empty, push, pop, ovr_set;
    logic [2:0]      clr;
    logic [15:0]     wdata, rdata;
    logic            unused_wbits;

    // Receiver FSM: sample at mid-bit, leave STOP at mid-stop so back-to-back frames work.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shreg_q, rx_s2_q};
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    frame_set = !rx_s2_q;
                    par_set   = par_bad_q;
                    push_req  = rx_s2_q && !par_bad_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hit_data = (d_addr == BASE_ADDR);
    assign hit_stat = (d_addr == STAT_ADDR);
    assign full     = (count_q == DEPTH_N);
    assign empty    = (count_q == '0);
    assign pop      = io_read && !io_read_q && hit_data && !empty;
    assign push     = push_req && (!full || pop);
    assign ovr_set  = push_req && full && !pop;
    assign wdata    = d_bus;
    assign clr      = (io_write && hit_stat) ? wdata[4:2] : 3'b000;
    assign unused_wbits = ^{wdata[15:5], wdata[1:0]};

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + NW'(1);
        else if (pop && !push) count_d = count_q - NW'(1);
    end

    always_comb begin
        rdata = 16'h0000;
        if (hit_stat)    rdata = {8'(count_q), 3'b000, par_err_q, frm_err_q, ovr_q, full, !empty};
        else if (!empty) rdata = {8'h00, mem_q[rd_ptr_q]};
    end

    assign d_bus = (io_read && (hit_data || hit_stat)) ? rdata : 16'hzzzz;
    assign irq   = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            par_bad_q <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            io_read_q <= 1'b0;
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            frm_err_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            par_bad_q <= par_bad_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            io_read_q <= io_read;
            irq_q     <= (count_q != '0);
            // A flag raised by the receiver in the same cycle as a clear stays set.
            ovr_q     <= ovr_set   || (ovr_q && !clr[0]);
            frm_err_q <= frame_set || (frm_err_q && !clr[1]);
            par_err_q <= PAR_EN && (par_set || (par_err_q && !clr[2]));
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Randomised bench for uart_rx_port with a queue-based model of the FIFO and sticky flags.
// Parity scenarios are built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_port;
    localparam int          CPB = 16;
    localparam logic [15:0] DA  = 16'hFF10;
    localparam logic [15:0] SA  = 16'hFF11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_val = 16'h0000;
    wire  [15:0] d_bus;
    logic        irq;

    assign d_bus = tb_drv ? tb_val : 16'hzzzz;

    uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .BASE_ADDR(DA)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .io_read(io_read), .io_write(io_write),
        .d_addr(d_addr), .d_bus(d_bus), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit stable = 1'b0;
    logic [7:0] mq[$];
    bit m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        int n = mq.size();
        logic [7:0] n8 = 8'(n);
        return {n8, 3'b000, m_par, m_frm, m_ovr, n == 16, n != 0};
    endfunction

    always @(negedge clk)
        if (stable && rst_n) chk("irq", {15'd0, irq}, {15'd0, mq.size() != 0});

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        bit pbad = 1'b0;
        stable = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? ^b : ~^b;
        repeat (CPB) @(negedge clk);
        pbad = !par_ok;
`endif
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) begin
            m_frm = 1'b1;
            repeat (4) @(negedge clk);
        end
        if (pbad) m_par = 1'b1;
        if (stop_ok && !pbad) begin
            if (mq.size() < 16) mq.push_back(b);
            else m_ovr = 1'b1;
        end
        stable = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] v);
        stable = 1'b0;
        @(negedge clk);
        d_addr = a;
        io_read = 1'b1;
        #1 v = d_bus;
        @(negedge clk);
        io_read = 1'b0;
        d_addr = 16'h0000;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        stable = 1'b1;
    endtask

    task automatic read_status(input string nm);
        logic [15:0] v;
        cpu_read(SA, v);
        chk(nm, v, exp_status());
        settle();
    endtask

    task automatic read_data(input string nm);
        logic [15:0] v, e;
        e = (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
        cpu_read(DA, v);
        chk(nm, v, e);
        if (mq.size() != 0) void'(mq.pop_front());
        settle();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] val);
        stable = 1'b0;
        @(negedge clk);
        d_addr = a; io_write = 1'b1; tb_drv = 1'b1; tb_val = val;
        @(negedge clk);
        io_write = 1'b0; tb_drv = 1'b0; d_addr = 16'h0000;
        if (a == SA) begin
            if (val[2]) m_ovr = 1'b0;
            if (val[3]) m_frm = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (val[4]) m_par = 1'b0;
`endif
        end
        settle();
    endtask

    task automatic lit_status(input string nm, input logic [15:0] lit);
        logic [15:0] v;
        cpu_read(SA, v);
        chk(nm, v, lit);
        chk({nm, "_model"}, exp_status(), lit);
        settle();
    endtask

    initial begin
        #900000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("reset_irq", {15'd0, irq}, 16'd0);
        lit_status("reset_status", 16'h0000);

        send_frame(8'hA5, 1'b1, 1'b1);
        lit_status("t1_status", 16'h0101);
        chk("t1_irq", {15'd0, irq}, 16'd1);
        cpu_read(DA, v);
        chk("t1_data", v, 16'h00A5);
        void'(mq.pop_front());
        settle();
        lit_status("t1_status_after", 16'h0000);
        chk("t1_irq_after", {15'd0, irq}, 16'd0);

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b1);
        lit_status("t2_full", 16'h1007);
        for (int i = 0; i < 16; i++) begin
            cpu_read(DA, v);
            chk("t2_data", v, 16'(i));
            void'(mq.pop_front());
            settle();
        end
        lit_status("t2_drained", 16'h0004);
        read_data("t2_empty_read");
        cpu_write(SA, 16'h0004);
        lit_status("t2_cleared", 16'h0000);

        send_frame(8'h3C, 1'b0, 1'b1);
        lit_status("t3_frame_err", 16'h0008);
        cpu_write(DA, 16'h0008);
        lit_status("t3_data_write_ignored", 16'h0008);
        cpu_write(SA, 16'h0008);
        lit_status("t3_cleared", 16'h0000);

        stable = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        stable = 1'b1;
        lit_status("t4_glitch", 16'h0000);
        send_frame(8'h77, 1'b1, 1'b1);
        read_data("t4_data");

        stable = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        mq.delete();
        m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("t5_irq", {15'd0, irq}, 16'd0);
        lit_status("t5_status", 16'h0000);
        send_frame(8'h5A, 1'b1, 1'b1);
        cpu_read(DA, v);
        chk("t5_data", v, 16'h005A);
        void'(mq.pop_front());
        settle();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        lit_status("t6_par_err", 16'h0010);
        send_frame(8'h01, 1'b1, 1'b1);
        lit_status("t6_par_ok", 16'h0111);
        cpu_write(SA, 16'h0010);
        read_data("t6_data");
        read_status("t6_status");
`endif

        send_frame(8'hC3, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        stable = 1'b0;
        @(negedge clk);
        d_addr = DA;
        io_read = 1'b1;
        #1 v = d_bus;
        repeat (5) @(negedge clk);
        io_read = 1'b0;
        d_addr = 16'h0000;
        chk("held_read", v, 16'h00C3);
        void'(mq.pop_front());
        settle();
        lit_status("held_read_once", 16'h0101);
        read_data("held_next");

        for (int it = 0; it < 60; it++) begin
            logic [7:0] b = 8'($urandom);
            bit sok = ($urandom_range(0, 7) != 0);
            bit pok = ($urandom_range(0, 7) != 0);
            send_frame(b, sok, pok);
            if ($urandom_range(0, 3) == 0) read_status("rnd_status");
            if ($urandom_range(0, 5) == 0) cpu_write(SA, 16'($urandom_range(0, 7)) << 2);
            for (int r = $urandom_range(0, 2); r > 0; r--) read_data("rnd_data");
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        read_status("rnd_final_status");
        while (mq.size() != 0) read_data("rnd_drain");
        read_status("rnd_drained_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
